// File: rtl/main_mem_arb_pkg.sv
// Shared types and constants for the main data memory arbiter.
package main_mem_arb_pkg;

  typedef enum logic [1:0] {
    ID_PIPE = 2'd0,
    ID_LOAD = 2'd1,
    ID_DBG  = 2'd2
  } req_id_e;

  localparam int RD_LAT = 2;
  localparam int DEF_AW = 12;
  localparam int DEF_DW = 16;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker with its own pointer; ptr=0 favours req[0].
module mem_arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick
);

  logic ptr;

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = ptr ? 2'b10 : 2'b01;
  end

  // After serving one side, favour the other; hold when nothing was taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ptr <= 1'b0;
    else if (advance) ptr <= pick[0];
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Single-port main memory arbiter: pipeline > round-robin(loader, debug).
// Optional starvation guard for loader/debug: MAIN_MEM_ARB_STARVE_GUARD_EN.
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          p_gnt,
  output logic          l_gnt,
  output logic          d_gnt,
  output logic          p_rvalid,
  output logic          l_rvalid,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic          m_rw,
  input  logic [DW-1:0] m_q
);

  logic [1:0]    rr_req;
  logic [1:0]    rr_pick;
  logic          pipe_win;
  logic          any_gnt;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  req_id_e       win_id;
  tag_t          tag_q [RD_LAT];
  tag_t          tag_out;

`ifdef MAIN_MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] l_wait, d_wait;
  logic          l_starve, d_starve, any_starve;

  assign l_starve   = l_req && (l_wait == CW'(MAX_WAIT));
  assign d_starve   = d_req && (d_wait == CW'(MAX_WAIT));
  assign any_starve = l_starve || d_starve;
  // A starving requester jumps the pipeline; two starving ones fall back to round-robin.
  assign rr_req     = any_starve ? {d_starve, l_starve} : {d_req, l_req};
  assign pipe_win   = p_req && !any_starve;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l_wait <= '0;
      d_wait <= '0;
    end else begin
      if (!l_req || l_gnt)               l_wait <= '0;
      else if (l_wait != CW'(MAX_WAIT))  l_wait <= l_wait + 1'b1;
      if (!d_req || d_gnt)               d_wait <= '0;
      else if (d_wait != CW'(MAX_WAIT))  d_wait <= d_wait + 1'b1;
    end
  end
`else
  assign rr_req   = {d_req, l_req};
  assign pipe_win = p_req;
`endif

  mem_arb_rr2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (rr_req),
    .advance (l_gnt | d_gnt),
    .pick    (rr_pick)
  );

  assign p_gnt   = reset && pipe_win;
  assign l_gnt   = reset && !pipe_win && rr_pick[0];
  assign d_gnt   = reset && !pipe_win && rr_pick[1];
  assign any_gnt = p_gnt | l_gnt | d_gnt;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_id    = ID_PIPE;
    if (p_gnt) begin
      win_we = p_we; win_addr = p_addr; win_wdata = p_wdata; win_id = ID_PIPE;
    end else if (l_gnt) begin
      win_we = l_we; win_addr = l_addr; win_wdata = l_wdata; win_id = ID_LOAD;
    end else if (d_gnt) begin
      win_we = d_we; win_addr = d_addr; win_wdata = d_wdata; win_id = ID_DBG;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_addr <= '0;
      m_data <= '0;
      m_rw   <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: any_gnt && !win_we, id: win_id};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      m_rw <= any_gnt && win_we;
      if (any_gnt) begin
        m_addr <= win_addr;
        m_data <= win_wdata;
      end
    end
  end

  assign tag_out  = tag_q[RD_LAT-1];
  assign p_rvalid = tag_out.valid && (tag_out.id == ID_PIPE);
  assign l_rvalid = tag_out.valid && (tag_out.id == ID_LOAD);
  assign d_rvalid = tag_out.valid && (tag_out.id == ID_DBG);
  assign rdata    = m_q;

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Arbitrates the single-port main data memory (12-bit address, 16-bit data, synchronous read) among three requesters: the processor's memory stage (pipeline), the program/data loader, and the debug/display reader. It sits between those clients and the memory pins (addr, data, rw, q). It issues at most one memory command per cycle and routes read data back to the requester that issued the read.

## Interface
Parameters:
- AW, 12, address width
- DW, 16, data width
- MAX_WAIT, 8, starvation threshold in cycles (used only with the guard macro)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- p_req / l_req / d_req  in  1  request from pipeline / loader / debug
- p_we / l_we / d_we  in  1  1 = write, 0 = read
- p_addr / l_addr / d_addr  in  AW  request address
- p_wdata / l_wdata / d_wdata  in  DW  write data
- p_gnt / l_gnt / d_gnt  out  1  grant, combinational, same cycle as accepted request
- p_rvalid / l_rvalid / d_rvalid  out  1  read data valid for that requester
- rdata  out  DW  read data, shared; qualified by the requester's rvalid
- m_addr  out  AW  memory address, registered
- m_data  out  DW  memory write data, registered
- m_rw  out  1  memory write enable (1 = write), registered
- m_q  in  DW  memory read data, valid one cycle after m_addr is presented

## Operation
- Requester rules: hold req, we, addr and wdata stable until a cycle in which gnt=1. Each gnt accepts exactly one transaction. A requester may keep req high to issue the next transaction in the following cycle.
- Priority: pipeline first. Loader and debug share round-robin via a 1-bit pointer. After a loader or debug grant, the pointer favours the other one. The pointer is unchanged on pipeline grants. Reset pointer favours loader.
- At most one gnt is high per cycle. No gnt is issued without the matching req.
- Issue: on a grant, m_addr, m_data and m_rw are loaded from the winner at the clock edge. If there is no grant, m_rw is 0 and m_addr/m_data hold their values.
- Return path: a 2-deep tag shift register holds {valid, id} for each granted read. For writes, valid=0.
- Read completion: when the tag valid bit emerges, assert the tagged requester's rvalid. rdata = m_q (combinational pass-through).
- Reset (asynchronous, reset low):
  - all gnt = 0, all rvalid = 0
  - m_rw = 0, m_addr = 0, m_data = 0
  - tag pipe cleared, so in-flight reads are discarded with no rvalid
  - pointer = loader

## Timing
- Cycle t: request present and gnt asserted.
- Edge ending t: command registered.
- Cycle t+1: m_addr/m_rw/m_data drive memory.
- Cycle t+2: rvalid=1 and rdata=m_q. Read latency is 2 cycles from grant.
- A write commits at the edge ending t+1.
- Throughput is 1 transaction per cycle. Back-to-back reads from different requesters return in issue order on consecutive cycles.
- Read following a write to the same address, granted in cycle t+1: returns the new data (memory is read after the write edge).
- Simultaneous p_req, l_req and d_req: pipeline wins. Loader and debug wait; the pointer does not move.

## Configuration
- MAIN_MEM_ARB_STARVE_GUARD_EN defined:
  - Loader and debug each have a saturating wait counter, width $clog2(MAX_WAIT+1).
  - A counter increments each cycle its req is high and not granted. It clears on grant or when req drops.
  - When a counter equals MAX_WAIT, that requester beats the pipeline for one grant.
  - If both counters are at MAX_WAIT, the round-robin pointer decides.
- Undefined: the pipeline has absolute priority and the counters are absent.

## Structure
- Package main_mem_arb_pkg holds:
  - requester id enum: ID_PIPE=2'd0, ID_LOAD=2'd1, ID_DBG=2'd2
  - read latency constant RD_LAT=2
  - default AW/DW values
- Sub-module mem_arb_rr2: a two-way round-robin picker (req pair, pointer, advance) producing a one-hot pick. It is instantiated once for loader/debug.

## Test plan
- Reset asserted mid-read (grant at t, reset low at t+1) -> no rvalid at t+2; m_rw=0, m_addr=0; after release, l_req is granted before d_req.
- Pipeline write addr 0x010 data 0xBEEF at t, pipeline read 0x010 at t+1 -> p_rvalid at t+3 with rdata=0xBEEF.
- l_req and d_req held continuously, no p_req -> grants alternate L,D,L,D each cycle; l_rvalid and d_rvalid return in the same alternating order, 2 cycles later.
- p_req, l_req and d_req all high for 3 cycles -> p_gnt every cycle; l_gnt and d_gnt stay 0 (guard off); the pointer is unchanged afterwards.
- Guard on, MAX_WAIT=8, p_req and l_req held high -> l_gnt in the 9th cycle of waiting, p_gnt in all others; the counter then restarts.
- Debug reads 0x3FF and loader writes 0x3FF in consecutive cycles -> debug gets the old value; a subsequent debug read gets the loader data.
